// File: rtl/msa_ternary_tracker_if.sv
// Sample/angle bus between the fine-error source and the ternary tracking counter.
interface msa_ternary_tracker_if #(
  parameter int unsigned ERR_W = 12,
  parameter int unsigned CNT_W = 16
);
  logic                    err_valid;
  logic signed [ERR_W-1:0] err;
  logic [1:0]              tlf2h;
  logic [1:0]              tlf1h;
  logic [CNT_W-1:0]        count;
  logic                    step_pulse;
  logic                    step_dir;

  modport master (
    output err_valid, err,
    input  tlf2h, tlf1h, count, step_pulse, step_dir
  );

  modport slave (
    input  err_valid, err,
    output tlf2h, tlf1h, count, step_pulse, step_dir
  );
endinterface

// File: rtl/msa_ternary_tracker.sv
// Two hysteretic ternary detectors on signed fine error driving a paced up/down angle counter.
// Optional MSA_ZERO_EN adds a zero_req input that clears count, detectors and pacer.
module msa_ternary_tracker #(
  parameter int unsigned ERR_W        = 12,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned HI_ON        = 600,
  parameter int unsigned HI_OFF       = 460,
  parameter int unsigned LO_ON        = 36,
  parameter int unsigned LO_OFF       = 27,
  parameter int unsigned PACE_DIV     = 4,
  parameter int unsigned COARSE_SHIFT = 6
) (
  input  logic clk,
  input  logic rst,
`ifdef MSA_ZERO_EN
  input  logic zero_req,
`endif
  msa_ternary_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    DET_ZERO = 2'b00,
    DET_POS  = 2'b01,
    DET_NEG  = 2'b10
  } det_state_t;

  localparam int unsigned EXT_W  = ERR_W + 1;
  localparam int unsigned PACE_W = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;

  // One extra bit keeps -ON and the most negative sample representable.
  localparam logic signed [EXT_W-1:0] HI_ON_X  = EXT_W'(HI_ON);
  localparam logic signed [EXT_W-1:0] HI_OFF_X = EXT_W'(HI_OFF);
  localparam logic signed [EXT_W-1:0] LO_ON_X  = EXT_W'(LO_ON);
  localparam logic signed [EXT_W-1:0] LO_OFF_X = EXT_W'(LO_OFF);

  localparam logic [PACE_W-1:0] PACE_LAST   = PACE_W'(PACE_DIV - 1);
  localparam logic [CNT_W-1:0]  COARSE_STEP = CNT_W'(1) << COARSE_SHIFT;
  localparam logic [CNT_W-1:0]  FINE_STEP   = CNT_W'(1);

  det_state_t              r_hi;
  det_state_t              r_lo;
  logic [PACE_W-1:0]       r_pace;
  logic [CNT_W-1:0]        r_count;
  logic                    r_step_pulse;
  logic                    r_step_dir;

  logic signed [EXT_W-1:0] w_err_x;
  logic                    w_opp;

  assign w_err_x = EXT_W'(bus.err);
  assign w_opp   = (r_pace == PACE_LAST);

  // Hysteretic ternary decision; reversals skip ZERO when the opposite ON level is crossed.
  function automatic det_state_t det_next(
    input det_state_t              s,
    input logic signed [EXT_W-1:0] e,
    input logic signed [EXT_W-1:0] on,
    input logic signed [EXT_W-1:0] off
  );
    det_state_t n;
    n = s;
    case (s)
      DET_ZERO: begin
        if (e >= on)       n = DET_POS;
        else if (e <= -on) n = DET_NEG;
      end
      DET_POS: begin
        if (e <= -on)      n = DET_NEG;
        else if (e < off)  n = DET_ZERO;
      end
      DET_NEG: begin
        if (e >= on)       n = DET_POS;
        else if (e > -off) n = DET_ZERO;
      end
      default: n = DET_ZERO;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi         <= DET_ZERO;
      r_lo         <= DET_ZERO;
      r_pace       <= '0;
      r_count      <= '0;
      r_step_pulse <= 1'b0;
      r_step_dir   <= 1'b0;
    end
`ifdef MSA_ZERO_EN
    else if (zero_req) begin
      r_hi         <= DET_ZERO;
      r_lo         <= DET_ZERO;
      r_pace       <= '0;
      r_count      <= '0;
      r_step_pulse <= 1'b0;
    end
`endif
    else begin
      r_step_pulse <= 1'b0;
      r_pace       <= w_opp ? '0 : r_pace + PACE_W'(1);

      // Coarse detector wins; steps use the states registered before this edge.
      if (w_opp) begin
        if (r_hi == DET_POS) begin
          r_count      <= r_count + COARSE_STEP;
          r_step_pulse <= 1'b1;
          r_step_dir   <= 1'b1;
        end else if (r_hi == DET_NEG) begin
          r_count      <= r_count - COARSE_STEP;
          r_step_pulse <= 1'b1;
          r_step_dir   <= 1'b0;
        end else if (r_lo == DET_POS) begin
          r_count      <= r_count + FINE_STEP;
          r_step_pulse <= 1'b1;
          r_step_dir   <= 1'b1;
        end else if (r_lo == DET_NEG) begin
          r_count      <= r_count - FINE_STEP;
          r_step_pulse <= 1'b1;
          r_step_dir   <= 1'b0;
        end
      end

      if (bus.err_valid) begin
        r_hi <= det_next(r_hi, w_err_x, HI_ON_X, HI_OFF_X);
        r_lo <= det_next(r_lo, w_err_x, LO_ON_X, LO_OFF_X);
      end
    end
  end

  assign bus.tlf2h      = r_hi;
  assign bus.tlf1h      = r_lo;
  assign bus.count      = r_count;
  assign bus.step_pulse = r_step_pulse;
  assign bus.step_dir   = r_step_dir;

endmodule
